// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Imported by the arbiter top and its round-robin sub-module.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        ACK
    } state_t;

    typedef enum logic {
        OWN_CORE,
        OWN_LDR
    } owner_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/dmem_arbiter_rr2.sv
// Two-requester arbiter (core vs. loader) with a remembered last grant.
// The winner is combinational; the last-grant record only moves on a grant strobe.
module arb_rr2
    import dmem_arb_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   c_req_i,
    input  logic   l_req_i,
    input  logic   loader_prio_i,
    input  logic   grant_en_i,
    output owner_t winner_o
);

    owner_t lastGrant_q;
    owner_t lastGrant_d;

    // On a tie the loader wins when prioritised, otherwise whoever was not served last.
    always_comb begin
        winner_o = OWN_CORE;
        if (c_req_i && l_req_i) begin
            if (loader_prio_i || (lastGrant_q == OWN_CORE)) begin
                winner_o = OWN_LDR;
            end
        end else if (l_req_i) begin
            winner_o = OWN_LDR;
        end
        lastGrant_d = grant_en_i ? winner_o : lastGrant_q;
    end

    // Starting as if the loader was served last lets the core win the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lastGrant_q <= OWN_LDR;
        end else begin
            lastGrant_q <= lastGrant_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port DMEM between the core load/store port and the loader port.
// Each access runs IDLE -> ACCESS -> (WAIT) -> ACK with registered memory and ack outputs.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int MEM_LAT     = 1,
    parameter int LOADER_PRIO = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              c_req_i,
    input  logic              c_rw_i,
    input  logic [ADDR_W-1:0] c_addr_i,
    input  logic [DATA_W-1:0] c_wdata_i,
    output logic [DATA_W-1:0] c_rdata_o,
    output logic              c_ack_o,
    output logic              c_stall_o,
    input  logic              l_req_i,
    input  logic              l_rw_i,
    input  logic [ADDR_W-1:0] l_addr_i,
    input  logic [DATA_W-1:0] l_wdata_i,
    output logic [DATA_W-1:0] l_rdata_o,
    output logic              l_ack_o,
    output logic              m_en_o,
    output logic              m_rw_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_wdata_o,
    input  logic [DATA_W-1:0] m_rdata_i
);

    if (MEM_LAT < 1 || MEM_LAT > 4) begin : gBadLat
        $error("dmem_arbiter: MEM_LAT must be in 1..4");
    end

    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    state_t            state_q;
    owner_t            owner_q;
    owner_t            winner;
    logic [1:0]        cnt_q;
    logic              mEn_q;
    logic              mRw_q;
    logic [ADDR_W-1:0] mAddr_q;
    logic [DATA_W-1:0] mWdata_q;
    logic [DATA_W-1:0] cRdata_q;
    logic [DATA_W-1:0] lRdata_q;
    logic              cAck_q;
    logic              lAck_q;
    logic              grantEn;

    assign grantEn = (state_q == IDLE) && (c_req_i || l_req_i);

    arb_rr2 u_arb (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .c_req_i       (c_req_i),
        .l_req_i       (l_req_i),
        .loader_prio_i (LOADER_PRIO != 0),
        .grant_en_i    (grantEn),
        .winner_o      (winner)
    );

    // The winner's request is frozen into the m_* registers at grant, so later
    // input changes from either side cannot disturb an access in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            owner_q  <= OWN_CORE;
            cnt_q    <= '0;
            mEn_q    <= 1'b0;
            mRw_q    <= RW_READ;
            mAddr_q  <= '0;
            mWdata_q <= '0;
            cRdata_q <= '0;
            lRdata_q <= '0;
            cAck_q   <= 1'b0;
            lAck_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grantEn) begin
                        owner_q <= winner;
                        mEn_q   <= 1'b1;
                        if (winner == OWN_LDR) begin
                            mRw_q    <= l_rw_i;
                            mAddr_q  <= l_addr_i;
                            mWdata_q <= l_wdata_i;
                        end else begin
                            mRw_q    <= c_rw_i;
                            mAddr_q  <= c_addr_i;
                            mWdata_q <= c_wdata_i;
                        end
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    mEn_q <= 1'b0;
                    if (mRw_q == RW_WRITE) begin
                        cAck_q  <= (owner_q == OWN_CORE);
                        lAck_q  <= (owner_q == OWN_LDR);
                        state_q <= ACK;
                    end else begin
                        cnt_q   <= CNT_INIT;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // Read data is valid in the cycle the counter reaches zero.
                    if (cnt_q == 2'd0) begin
                        if (owner_q == OWN_LDR) begin
                            lRdata_q <= m_rdata_i;
                        end else begin
                            cRdata_q <= m_rdata_i;
                        end
                        cAck_q  <= (owner_q == OWN_CORE);
                        lAck_q  <= (owner_q == OWN_LDR);
                        state_q <= ACK;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                ACK: begin
                    cAck_q  <= 1'b0;
                    lAck_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign c_rdata_o = cRdata_q;
    assign l_rdata_o = lRdata_q;
    assign c_ack_o   = cAck_q;
    assign l_ack_o   = lAck_q;
    assign c_stall_o = c_req_i & ~cAck_q;
    assign m_en_o    = mEn_q;
    assign m_rw_o    = mRw_q;
    assign m_addr_o  = mAddr_q;
    assign m_wdata_o = mWdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance 0 uses MEM_LAT=1 round-robin, instance 1 uses
// MEM_LAT=3 loader-first; each has its own behavioural DMEM with exact read latency.
module tb_dmem_arbiter;

    typedef struct {
        int          d;
        bit          ldr;
        bit          rd;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        int          expLat;
    } vec_t;

    typedef struct {
        int          d;
        bit          ldr;
        bit          rd;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cReq [2];
    logic        cRw [2];
    logic [9:0]  cAddr [2];
    logic [31:0] cWdata [2];
    logic [31:0] cRdata [2];
    logic        cAck [2];
    logic        cStall [2];
    logic        lReq [2];
    logic        lRw [2];
    logic [9:0]  lAddr [2];
    logic [31:0] lWdata [2];
    logic [31:0] lRdata [2];
    logic        lAck [2];
    logic        mEn [2];
    logic        mRw [2];
    logic [9:0]  mAddr [2];
    logic [31:0] mWdata [2];
    logic [31:0] mRdata [2];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    exp_t        sbQ [$];
    vec_t        vecs [11];
    logic [31:0] expC [2];
    logic [31:0] expL [2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1), .LOADER_PRIO(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst),
        .c_req_i(cReq[0]), .c_rw_i(cRw[0]), .c_addr_i(cAddr[0]), .c_wdata_i(cWdata[0]),
        .c_rdata_o(cRdata[0]), .c_ack_o(cAck[0]), .c_stall_o(cStall[0]),
        .l_req_i(lReq[0]), .l_rw_i(lRw[0]), .l_addr_i(lAddr[0]), .l_wdata_i(lWdata[0]),
        .l_rdata_o(lRdata[0]), .l_ack_o(lAck[0]),
        .m_en_o(mEn[0]), .m_rw_o(mRw[0]), .m_addr_o(mAddr[0]), .m_wdata_o(mWdata[0]),
        .m_rdata_i(mRdata[0])
    );

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(3), .LOADER_PRIO(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .c_req_i(cReq[1]), .c_rw_i(cRw[1]), .c_addr_i(cAddr[1]), .c_wdata_i(cWdata[1]),
        .c_rdata_o(cRdata[1]), .c_ack_o(cAck[1]), .c_stall_o(cStall[1]),
        .l_req_i(lReq[1]), .l_rw_i(lRw[1]), .l_addr_i(lAddr[1]), .l_wdata_i(lWdata[1]),
        .l_rdata_o(lRdata[1]), .l_ack_o(lAck[1]),
        .m_en_o(mEn[1]), .m_rw_o(mRw[1]), .m_addr_o(mAddr[1]), .m_wdata_o(mWdata[1]),
        .m_rdata_i(mRdata[1])
    );

    // Read data appears only in the single cycle MEM_LAT after m_en; other cycles carry junk.
    for (genvar g = 0; g < 2; g++) begin : gMem
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] mem [1024];
        logic [31:0] pipe [LAT];
        always @(posedge clk) begin
            if (mEn[g] && !mRw[g]) mem[mAddr[g]] <= mWdata[g];
            pipe[0] <= (mEn[g] && mRw[g]) ? mem[mAddr[g]] : 32'hBAD0BAD0;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign mRdata[g] = pipe[LAT-1];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every ack retires the oldest expectation; owner, instance and read data must match.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (cAck[d] || lAck[d]) begin
                checkOutput("ackOverlap", 32'(cAck[d] & lAck[d]), 32'd0);
                if (sbQ.size() == 0) begin
                    checkOutput("unexpectedAck", 32'(sbQ.size()), 32'd1);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("sbDut", 32'(d), 32'(e.d));
                    checkOutput("sbOwner", 32'(lAck[d]), 32'(e.ldr));
                    if (e.rd) checkOutput("sbRdata", e.ldr ? lRdata[d] : cRdata[d], e.rdata);
                end
            end
        end
    end

    task automatic waitAck(input int d, input bit ldr, input bit rd, input logic [9:0] addr,
                           input logic [31:0] wdata, output int lat);
        int en = 0;
        bit seen = 0;
        lat = 0;
        while (!seen && lat < 30) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (mEn[d]) begin
                en++;
                checkOutput("mAddr", 32'(mAddr[d]), 32'(addr));
                checkOutput("mRw", 32'(mRw[d]), 32'(rd));
                if (!rd) checkOutput("mWdata", mWdata[d], wdata);
            end
            seen = ldr ? lAck[d] : cAck[d];
            if (!ldr) checkOutput(seen ? "stallAtAck" : "stallBusy", 32'(cStall[d]), seen ? 32'd0 : 32'd1);
        end
        checkOutput("ackSeen", 32'(seen), 32'd1);
        checkOutput("mEnPulses", 32'(en), 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        int lat;
        @(negedge clk);
        if (v.ldr) begin
            lReq[v.d] = 1'b1; lRw[v.d] = v.rd; lAddr[v.d] = v.addr; lWdata[v.d] = v.wdata;
        end else begin
            cReq[v.d] = 1'b1; cRw[v.d] = v.rd; cAddr[v.d] = v.addr; cWdata[v.d] = v.wdata;
        end
        sbQ.push_back('{v.d, v.ldr, v.rd, v.expRdata});
        waitAck(v.d, v.ldr, v.rd, v.addr, v.wdata, lat);
        cReq[v.d] = 1'b0;
        lReq[v.d] = 1'b0;
        checkOutput("latency", 32'(lat), 32'(v.expLat));
        if (v.rd && v.ldr) expL[v.d] = v.expRdata;
        if (v.rd && !v.ldr) expC[v.d] = v.expRdata;
        checkOutput("cRdataHold", cRdata[v.d], expC[v.d]);
        checkOutput("lRdataHold", lRdata[v.d], expL[v.d]);
    endtask

    // Both sides request reads and hold until they have been served the wanted number of times.
    task automatic runPair(input int d, input logic [9:0] ca, input logic [9:0] la,
                           input int wantC, input int wantL, input int gap);
        int nC = 0;
        int nL = 0;
        int n = 0;
        int lastAck = -1;
        @(negedge clk);
        cReq[d] = 1'b1; cRw[d] = 1'b1; cAddr[d] = ca;
        lReq[d] = 1'b1; lRw[d] = 1'b1; lAddr[d] = la;
        while ((nC < wantC || nL < wantL) && n < 80) begin
            @(negedge clk);
            n++;
            if (cAck[d] || lAck[d]) begin
                if (lastAck >= 0) checkOutput("ackSpacing", 32'(cyc - lastAck), 32'(gap));
                lastAck = cyc;
            end
            if (cAck[d]) begin
                nC++;
                if (nC == wantC) cReq[d] = 1'b0;
            end
            if (lAck[d]) begin
                nL++;
                if (nL == wantL) lReq[d] = 1'b0;
            end
        end
        checkOutput("pairCoreAcks", 32'(nC), 32'(wantC));
        checkOutput("pairLdrAcks", 32'(nL), 32'(wantL));
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            cReq[d] = 0; cRw[d] = 0; cAddr[d] = '0; cWdata[d] = '0;
            lReq[d] = 0; lRw[d] = 0; lAddr[d] = '0; lWdata[d] = '0;
            expC[d] = '0; expL[d] = '0;
        end

        //         d  ldr rd  addr      wdata         expRdata      lat
        vecs[0]  = '{0, 0, 0, 10'h004, 32'hDEADBEEF, 32'h0,        2};
        vecs[1]  = '{0, 1, 0, 10'h010, 32'h12345678, 32'h0,        2};
        vecs[2]  = '{0, 0, 1, 10'h010, 32'h0,        32'h12345678, 3};
        vecs[3]  = '{0, 1, 0, 10'h007, 32'hA5A5A5A5, 32'h0,        2};
        vecs[4]  = '{0, 0, 1, 10'h007, 32'h0,        32'hA5A5A5A5, 3};
        vecs[5]  = '{0, 0, 1, 10'h004, 32'h0,        32'hDEADBEEF, 3};
        vecs[6]  = '{0, 0, 0, 10'h3FF, 32'hFFFFFFFF, 32'h0,        2};
        vecs[7]  = '{0, 1, 1, 10'h3FF, 32'h0,        32'hFFFFFFFF, 3};
        vecs[8]  = '{1, 1, 0, 10'h010, 32'h12345678, 32'h0,        2};
        vecs[9]  = '{1, 0, 1, 10'h010, 32'h0,        32'h12345678, 5};
        vecs[10] = '{1, 1, 1, 10'h010, 32'h0,        32'h12345678, 5};

        repeat (2) @(negedge clk);
        checkOutput("rstMEn", 32'(mEn[0]), 32'd0);
        checkOutput("rstMRw", 32'(mRw[0]), 32'd1);
        checkOutput("rstMAddr", 32'(mAddr[0]), 32'd0);
        checkOutput("rstMWdata", mWdata[0], 32'd0);
        checkOutput("rstCAck", 32'(cAck[0]), 32'd0);
        checkOutput("rstLAck", 32'(lAck[0]), 32'd0);
        checkOutput("rstCRdata", cRdata[0], 32'd0);
        checkOutput("rstLRdata", lRdata[0], 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

        // Round-robin: the loader was served last on instance 0, so the core leads.
        sbQ.push_back('{0, 0, 1, 32'hA5A5A5A5});
        sbQ.push_back('{0, 1, 1, 32'h12345678});
        sbQ.push_back('{0, 0, 1, 32'hA5A5A5A5});
        sbQ.push_back('{0, 1, 1, 32'h12345678});
        runPair(0, 10'h007, 10'h010, 2, 2, 4);

        // Loader-first: the loader keeps winning while it requests, then the core goes.
        sbQ.push_back('{1, 1, 1, 32'h12345678});
        sbQ.push_back('{1, 1, 1, 32'h12345678});
        sbQ.push_back('{1, 0, 1, 32'h12345678});
        runPair(1, 10'h010, 10'h010, 1, 2, 6);

        // Asynchronous reset while a MEM_LAT=3 read sits in WAIT.
        @(negedge clk);
        cReq[1] = 1'b1; cRw[1] = 1'b1; cAddr[1] = 10'h010;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("midRstMEn", 32'(mEn[1]), 32'd0);
        checkOutput("midRstCAck", 32'(cAck[1]), 32'd0);
        checkOutput("midRstMAddr", 32'(mAddr[1]), 32'd0);
        checkOutput("midRstCRdata", cRdata[1], 32'd0);
        checkOutput("midRstStall", 32'(cStall[1]), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        sbQ.push_back('{1, 0, 1, 32'h12345678});
        waitAck(1, 1'b0, 1'b1, 10'h010, 32'h0, lat);
        cReq[1] = 1'b0;
        checkOutput("rstRestartLat", 32'(lat), 32'd5);

        repeat (3) @(negedge clk);
        checkOutput("sbEmpty", 32'(sbQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
